machine_work_queue: RTL and testbench
=====================================

# machine_work_queue

Parametrised deque of pending machine work items: button count, flattened button masks and flattened joltage targets. It sits between the input parser / search expander and the solver cores. It generalises the earlier push/pop line buffer in four ways:
- valid/ready handshakes on both sides;
- same-cycle push and pop;
- push-to-front, giving depth-first ordering;
- flush, occupancy, almost-full and high-water-mark reporting.

The head element is always presented on registered outputs (show-ahead).

## Interface
Parameters:
- DEPTH, 256, maximum stored elements; any integer ≥ 2, not restricted to powers of two.
- MAX_BUTTON_COUNT, 13, buttons per machine.
- MACHINE_COUNT, 10, joltage counters per machine.
- BITS_PER_JOLTAGE, 9, width of one joltage value.
- ALMOST_FULL_LEVEL, DEPTH-4, occupancy at or above which almost_full is asserted.

Derived widths:
- BCW = $clog2(MAX_BUTTON_COUNT+1)
- BW = MACHINE_COUNT*MAX_BUTTON_COUNT
- JW = MACHINE_COUNT*BITS_PER_JOLTAGE
- CW = $clog2(DEPTH+1)

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of contents.
- in_valid  in  1  producer offers an element.
- in_ready  out  1  queue can accept; registered.
- in_front  in  1  1 = insert at head, 0 = append at tail; sampled with in_valid.
- in_button_count  in  BCW  element field.
- in_flattened_buttons  in  BW  element field.
- in_flattened_machines  in  JW  element field.
- out_valid  out  1  head element present.
- out_ready  in  1  consumer takes the head.
- out_button_count  out  BCW  head field.
- out_flattened_buttons  out  BW  head field.
- out_flattened_machines  out  JW  head field.
- count  out  CW  elements stored, including head.
- almost_full  out  1  count ≥ ALMOST_FULL_LEVEL.
- max_count  out  CW  highest count since reset.

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready. Both are evaluated in the same cycle and both may occur.
- in_ready = (count < DEPTH), computed from registered state only. There is no combinational path from out_ready to in_ready. When full, a same-cycle pop does not enable a push.
- Back push, no pop: the element is appended after the current tail.
- Front push, no pop: the element becomes the head; the previous head becomes second.
- Pop, no push: the head is removed; the next element becomes the head.
- Back push + pop: the head is removed and the element is appended. Count is unchanged. If count was 1, the pushed element becomes the head.
- Front push + pop: the old head is removed and the pushed element becomes the head. Count is unchanged.
- Push into an empty queue: the element becomes the head. Back and front push are identical in this case.
- Pop while empty: impossible, since out_valid = 0. out_ready is ignored.
- Storage indices wrap explicitly at DEPTH-1 → 0 and 0 → DEPTH-1. Front push decrements the head index; back push increments the tail index.
- Flush has priority over push and pop in the same cycle. It clears count to 0 and out_valid to 0. It does not clear max_count. Any simultaneous push is discarded.
- max_count is updated to the new count whenever the new count exceeds it.
- out_* data fields are don't-care while out_valid = 0. They retain their last value and are not zeroed, except by reset.

## Timing
- All outputs are registered and reflect the state after the edge on which an operation is accepted.
- Push into an empty queue: out_valid and the head fields are valid in the next cycle. Latency is 1 cycle.
- After a pop, the next head appears on the following cycle. Back-to-back pops every cycle are supported at full throughput.
- count, almost_full, in_ready and max_count update 1 cycle after the handshake edge.
- Reset values:
  - count = 0, out_valid = 0, in_ready = 1, almost_full = 0 (for ALMOST_FULL_LEVEL > 0), max_count = 0.
  - out_* data fields = 0.
  - Storage contents are not reset.
- Reset mid-operation discards all contents. The reset values hold on the cycle following the reset edge.
- Flush: count = 0, out_valid = 0, in_ready = 1 in the next cycle.

## Test plan
- Reset; back-push A, B, C on consecutive cycles with out_ready = 0 → count 1, 2, 3; out_valid = 1 from the cycle after A; head = A throughout; max_count = 3.
- From that state, hold out_ready = 1 → heads A, B, C on consecutive cycles; out_valid = 0 and count = 0 after C; max_count stays 3.
- Back-push A, B, then front-push X → head X, count 3; draining yields X, A, B.
- DEPTH = 5, ALMOST_FULL_LEVEL = 4:
  - Push 6 consecutive → almost_full rises after the 4th push; in_ready = 0 after the 5th; the 6th is not accepted; count = 5.
  - Then 12 rounds of pop-2/push-2 → FIFO order preserved across index wrap.
- count = 2 (A, B), same-cycle back push C + pop → count 2, drain B, C. Same-cycle front push Y + pop on A, B → head Y, count 2, drain Y, B.
- Flush asserted with in_valid = 1 at count 3 → next cycle count 0, out_valid 0, in_ready 1, max_count 3. Reset asserted mid-stream → every output at its reset value the following cycle.

Source files
------------

// File: rtl/machine_work_queue.sv
// Show-ahead deque of pending machine work items with front/back insertion,
// valid/ready on both sides, flush, and occupancy / high-water reporting.
module machine_work_queue #(
  parameter int DEPTH             = 256,
  parameter int MAX_BUTTON_COUNT  = 13,
  parameter int MACHINE_COUNT     = 10,
  parameter int BITS_PER_JOLTAGE  = 9,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 4,
  localparam int BCW = $clog2(MAX_BUTTON_COUNT + 1),
  localparam int BW  = MACHINE_COUNT * MAX_BUTTON_COUNT,
  localparam int JW  = MACHINE_COUNT * BITS_PER_JOLTAGE,
  localparam int CW  = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_front,
  input  logic [BCW-1:0] in_button_count,
  input  logic [BW-1:0]  in_flattened_buttons,
  input  logic [JW-1:0]  in_flattened_machines,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BCW-1:0] out_button_count,
  output logic [BW-1:0]  out_flattened_buttons,
  output logic [JW-1:0]  out_flattened_machines,
  output logic [CW-1:0]  count,
  output logic           almost_full,
  output logic [CW-1:0]  max_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int EW = BCW + BW + JW;

  logic [EW-1:0] mem [DEPTH];

  logic [IW-1:0] head_idx;
  logic [IW-1:0] tail_idx;
  logic [IW-1:0] head_idx_next;
  logic [IW-1:0] tail_idx_next;
  logic [CW-1:0] count_next;
  logic          valid_next;
  logic          push;
  logic          pop;
  logic          head_load;
  logic [EW-1:0] head_next;
  logic [EW-1:0] in_elem;
  logic [EW-1:0] second_elem;
  logic          wr_en;
  logic [IW-1:0] wr_addr;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
  endfunction

  function automatic logic [IW-1:0] idx_dec(input logic [IW-1:0] i);
    return (i == '0) ? IW'(DEPTH - 1) : i - IW'(1);
  endfunction

  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign in_elem     = {in_button_count, in_flattened_buttons, in_flattened_machines};
  assign second_elem = mem[idx_inc(head_idx)];

  // Next-state: tail_idx always equals head_idx + count (mod DEPTH).
  always_comb begin
    head_idx_next = head_idx;
    tail_idx_next = tail_idx;
    count_next    = count;
    valid_next    = out_valid;
    head_load     = 1'b0;
    head_next     = in_elem;
    wr_en         = 1'b0;
    wr_addr       = tail_idx;
    if (flush) begin
      count_next    = '0;
      valid_next    = 1'b0;
      tail_idx_next = head_idx;
    end else begin
      case ({push, pop})
        2'b10: begin
          wr_en      = 1'b1;
          count_next = count + CW'(1);
          valid_next = 1'b1;
          if (in_front) begin
            head_idx_next = idx_dec(head_idx);
            wr_addr       = idx_dec(head_idx);
            head_load     = 1'b1;
          end else begin
            wr_addr       = tail_idx;
            tail_idx_next = idx_inc(tail_idx);
            head_load     = (count == '0);
          end
        end
        2'b01: begin
          head_idx_next = idx_inc(head_idx);
          count_next    = count - CW'(1);
          valid_next    = (count > CW'(1));
          head_load     = (count > CW'(1));
          head_next     = second_elem;
        end
        2'b11: begin
          wr_en      = 1'b1;
          valid_next = 1'b1;
          head_load  = 1'b1;
          if (in_front) begin
            // New element overwrites the departing head in place.
            wr_addr = head_idx;
          end else begin
            wr_addr       = tail_idx;
            tail_idx_next = idx_inc(tail_idx);
            head_idx_next = idx_inc(head_idx);
            head_next     = (count == CW'(1)) ? in_elem : second_elem;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_elem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_idx               <= '0;
      tail_idx               <= '0;
      count                  <= '0;
      out_valid              <= 1'b0;
      in_ready               <= 1'b1;
      almost_full            <= (ALMOST_FULL_LEVEL <= 0);
      max_count              <= '0;
      out_button_count       <= '0;
      out_flattened_buttons  <= '0;
      out_flattened_machines <= '0;
    end else begin
      head_idx    <= head_idx_next;
      tail_idx    <= tail_idx_next;
      count       <= count_next;
      out_valid   <= valid_next;
      in_ready    <= (count_next < CW'(DEPTH));
      almost_full <= (32'(count_next) >= ALMOST_FULL_LEVEL);
      if (count_next > max_count) max_count <= count_next;
      if (head_load) begin
        {out_button_count, out_flattened_buttons, out_flattened_machines} <= head_next;
      end
    end
  end

endmodule

// File: tb/tb_machine_work_queue.sv
// Scoreboard bench for machine_work_queue: a reference deque predicts every
// popped head and the occupancy/status outputs after each clock edge.
module tb_machine_work_queue;

  localparam int DEPTH = 5;
  localparam int AFL   = 4;
  localparam int MBC   = 13;
  localparam int MC    = 10;
  localparam int BPJ   = 9;
  localparam int BCW   = $clog2(MBC + 1);
  localparam int BW    = MC * MBC;
  localparam int JW    = MC * BPJ;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = BCW + BW + JW;

  logic           clk = 1'b0;
  logic           reset, flush, in_valid, in_ready, in_front, out_valid, out_ready, almost_full;
  logic [BCW-1:0] in_button_count, out_button_count;
  logic [BW-1:0]  in_flattened_buttons, out_flattened_buttons;
  logic [JW-1:0]  in_flattened_machines, out_flattened_machines;
  logic [CW-1:0]  count, max_count;

  logic [EW-1:0] sb [$];
  int            mx;
  int            tests = 0;
  int            fails = 0;

  machine_work_queue #(
    .DEPTH(DEPTH), .MAX_BUTTON_COUNT(MBC), .MACHINE_COUNT(MC),
    .BITS_PER_JOLTAGE(BPJ), .ALMOST_FULL_LEVEL(AFL)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_front(in_front),
    .in_button_count(in_button_count), .in_flattened_buttons(in_flattened_buttons),
    .in_flattened_machines(in_flattened_machines),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_button_count(out_button_count), .out_flattened_buttons(out_flattened_buttons),
    .out_flattened_machines(out_flattened_machines),
    .count(count), .almost_full(almost_full), .max_count(max_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] rnd_elem();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w[EW-1:0];
  endfunction

  function automatic logic [EW-1:0] head_out();
    return {out_button_count, out_flattened_buttons, out_flattened_machines};
  endfunction

  task automatic check_state();
    check("count", 256'(count), 256'(sb.size()));
    check("out_valid", 256'(out_valid), 256'(sb.size() > 0));
    check("in_ready", 256'(in_ready), 256'(sb.size() < DEPTH));
    check("almost_full", 256'(almost_full), 256'(sb.size() >= AFL));
    check("max_count", 256'(max_count), 256'(mx));
    if (sb.size() > 0) check("head", 256'(head_out()), 256'(sb[0]));
  endtask

  task automatic step(input logic v, input logic front, input logic [EW-1:0] e,
                      input logic rdy, input logic fl);
    logic do_push, do_pop;
    in_valid = v;
    in_front = front;
    {in_button_count, in_flattened_buttons, in_flattened_machines} = e;
    out_ready = rdy;
    flush = fl;
    do_push = v && (sb.size() < DEPTH);
    do_pop  = rdy && (sb.size() > 0);
    if (fl) begin
      sb.delete();
    end else begin
      if (do_pop) begin
        check("pop_head", 256'(head_out()), 256'(sb[0]));
        void'(sb.pop_front());
      end
      if (do_push) begin
        if (front) sb.push_front(e);
        else sb.push_back(e);
      end
    end
    if (sb.size() > mx) mx = sb.size();
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_front = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset(input logic busy);
    idle_inputs();
    in_valid = busy;
    out_ready = busy;
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    mx = 0;
    check_state();
    check("rst_out_data", 256'(head_out()), 256'(0));
    reset = 1'b0;
  endtask

  task automatic push_n(input int n, input logic front);
    for (int i = 0; i < n; i++) step(1'b1, front, rnd_elem(), 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    {in_button_count, in_flattened_buttons, in_flattened_machines} = '0;
    idle_inputs();
    reset = 1'b1;
    mx = 0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    // A, B, C to the tail, then drain at full rate
    push_n(3, 1'b0);
    pop_n(4);

    // A, B at the tail, X at the front -> X, A, B
    push_n(2, 1'b0);
    push_n(1, 1'b1);
    pop_n(3);

    // Fill past capacity, then pop-2/push-2 across index wrap
    push_n(6, 1'b0);
    for (int r = 0; r < 12; r++) begin
      pop_n(2);
      push_n(2, 1'b0);
    end
    pop_n(DEPTH);

    // Same-cycle back push + pop, then front push + pop
    push_n(2, 1'b0);
    step(1'b1, 1'b0, rnd_elem(), 1'b1, 1'b0);
    pop_n(2);
    push_n(2, 1'b0);
    step(1'b1, 1'b1, rnd_elem(), 1'b1, 1'b0);
    pop_n(2);

    // Back push + pop with a single element present
    push_n(1, 1'b0);
    step(1'b1, 1'b0, rnd_elem(), 1'b1, 1'b0);
    pop_n(1);

    // Front push into empty, full queue with same-cycle pop
    push_n(1, 1'b1);
    push_n(4, 1'b1);
    step(1'b1, 1'b0, rnd_elem(), 1'b1, 1'b0);
    pop_n(DEPTH);

    // Flush with a simultaneous push and pop
    push_n(3, 1'b0);
    step(1'b1, 1'b0, rnd_elem(), 1'b1, 1'b1);
    push_n(1, 1'b0);
    pop_n(1);

    // Randomised mix
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), rnd_elem(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end

    // Reset in the middle of traffic
    push_n(3, 1'b0);
    do_reset(1'b1);
    push_n(2, 1'b1);
    pop_n(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
